// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between a CPU port and a DMA port
module alu_arbiter #(
  parameter int DATA_W  = 16,
  parameter int FLAG_W  = 6,
  parameter int INV_BIT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] op0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] op1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] res_c,
  output logic [FLAG_W-1:0] psr0,
  output logic [FLAG_W-1:0] psr1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_op,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [FLAG_W-1:0] alu_flags
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d, err_q, err_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, op_q, op_d, res_q, res_d;
  logic [FLAG_W-1:0] psr0_q, psr0_d, psr1_q, psr1_d;
  logic              any_req, win;
  assign any_req = req0 | req1;
  assign win     = (req0 & req1) ? ~last_q : req1;
  // next state: capture the ALU result in EXEC, otherwise arbitrate and latch the winner's operands
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    psr0_d  = psr0_q;
    psr1_d  = psr1_q;
    if (state_q == EXEC) begin
      state_d = DONE;
      res_d   = alu_c;
      err_d   = alu_flags[INV_BIT];
      psr0_d  = owner_q ? psr0_q : alu_flags;
      psr1_d  = owner_q ? alu_flags : psr1_q;
    end else if (any_req) begin
      state_d = EXEC;
      owner_d = win;
      last_d  = win;
      a_d     = win ? a1 : a0;
      b_d     = win ? b1 : b0;
      op_d    = win ? op1 : op0;
    end else begin
      state_d = IDLE;
    end
  end
  // state and datapath registers; last grant resets to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      psr0_q  <= '0;
      psr1_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      psr0_q  <= psr0_d;
      psr1_q  <= psr1_d;
    end
  end
  assign gnt0   = (state_q == EXEC) & ~owner_q;
  assign gnt1   = (state_q == EXEC) & owner_q;
  assign done0  = (state_q == DONE) & ~owner_q;
  assign done1  = (state_q == DONE) & owner_q;
  assign err0   = done0 & err_q;
  assign err1   = done1 & err_q;
  assign res_c  = res_q;
  assign psr0   = psr0_q;
  assign psr1   = psr1_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of the two-port ALU arbiter
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, op0 = '0, a1 = '0, b1 = '0, op1 = '0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [15:0] res_c, alu_a, alu_b, alu_op, alu_c;
  logic [5:0]  psr0, psr1, alu_flags;
  int          vectors = 0;
  int          errs = 0;

  alu_arbiter #(.DATA_W(16), .FLAG_W(6), .INV_BIT(5)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .res_c(res_c), .psr0(psr0), .psr1(psr1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // bench ALU: op[15:12] 0 add, 1 sub, 2 and, 3 or, 4 xor, others invalid
  // flags: [5] invalid, [2] negative, [1] zero, [0] carry
  function automatic logic [21:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] op);
    logic [16:0] s;
    logic        inv;
    s = '0;
    inv = 1'b0;
    case (op[15:12])
      4'h0: s = {1'b0, a} + {1'b0, b};
      4'h1: s = {1'b0, a} - {1'b0, b};
      4'h2: s = {1'b0, a & b};
      4'h3: s = {1'b0, a | b};
      4'h4: s = {1'b0, a ^ b};
      default: inv = 1'b1;
    endcase
    return {inv, 2'b00, s[15], s[15:0] == 16'h0, s[16], s[15:0]};
  endfunction

  assign {alu_flags, alu_c} = alu_fn(alu_a, alu_b, alu_op);

  function automatic logic [15:0] rop();
    return {4'($urandom_range(0, 6)), 12'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({gnt0, gnt1, done0, done1, err0, err1, res_c, psr0, psr1, alu_a, alu_b, alu_op} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %h want 0", {gnt0, gnt1, done0, done1, err0, err1, res_c, psr0, psr1, alu_a, alu_b, alu_op});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req0 = 1'b1; a0 = 16'h0003; b0 = 16'h0004; op0 = 16'h0000;
    tick();
    vectors++;
    if ({gnt0, gnt1, done0, done1} !== 4'b1000) begin
      errs++; $display("FAIL single_gnt: got %b want 1000", {gnt0, gnt1, done0, done1});
    end
    tick();
    vectors++;
    if ({gnt0, gnt1, done0, done1, err0} !== 5'b00100) begin
      errs++; $display("FAIL single_done: got %b want 00100", {gnt0, gnt1, done0, done1, err0});
    end
    vectors++;
    if (res_c !== 16'h0007) begin errs++; $display("FAIL single_res: got %h want 0007", res_c); end
    vectors++;
    if ({psr0, psr1} !== 12'h000) begin errs++; $display("FAIL single_psr: got %h want 000", {psr0, psr1}); end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({gnt0, done0, err0, res_c} !== {3'b000, 16'h0007}) begin
      errs++; $display("FAIL single_hold: got %h want 0007", {gnt0, done0, err0, res_c});
    end
    vectors++;
    if ({alu_a, alu_b, alu_op} !== {16'h0003, 16'h0004, 16'h0000}) begin
      errs++; $display("FAIL single_alu_hold: got %h want 000300040000", {alu_a, alu_b, alu_op});
    end
  endtask

  task automatic test_operand_change();
    req0 = 1'b1; a0 = 16'h0010; b0 = 16'h0001; op0 = 16'h0000;
    tick();
    a0 = 16'hFFFF;
    tick();
    vectors++;
    if ({done0, res_c} !== {1'b1, 16'h0011}) begin
      errs++; $display("FAIL opchange_res: got %h want 10011", {done0, res_c});
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_invalid();
    req0 = 1'b1; a0 = 16'hFFFF; b0 = 16'h0001; op0 = 16'h0000;
    tick();
    tick();
    vectors++;
    if ({res_c, psr0} !== {16'h0000, 6'b000011}) begin
      errs++; $display("FAIL inv_pre_psr0: got %h want 00003", {res_c, psr0});
    end
    req0 = 1'b0;
    req1 = 1'b1; a1 = 16'h1234; b1 = 16'h0001; op1 = 16'hF000;
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b01) begin errs++; $display("FAIL inv_gnt: got %b want 01", {gnt0, gnt1}); end
    a1 = 16'h5555;
    tick();
    vectors++;
    if ({done0, done1, err0, err1} !== 4'b0101) begin
      errs++; $display("FAIL inv_err: got %b want 0101", {done0, done1, err0, err1});
    end
    vectors++;
    if ({res_c, psr1, psr0} !== {16'h0000, 6'b100010, 6'b000011}) begin
      errs++; $display("FAIL inv_psr: got %h want %h", {res_c, psr1, psr0}, {16'h0000, 6'b100010, 6'b000011});
    end
    req1 = 1'b0;
    tick();
    vectors++;
    if ({done1, err1} !== 2'b00) begin errs++; $display("FAIL inv_err_clear: got %b want 00", {done1, err1}); end
  endtask

  task automatic test_simultaneous();
    int k = 0;
    int last_n = 0;
    int drop0 = -1, drop1 = -1;
    do_reset();
    req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001; op0 = 16'h0000;
    req1 = 1'b1; a1 = 16'h0002; b1 = 16'h0002; op1 = 16'h0000;
    for (int n = 0; n < 20 && k < 4; n++) begin
      tick();
      vectors++;
      if (gnt0 && gnt1) begin errs++; $display("FAIL sim_both_gnt: got 11 want not both"); end
      if (!req0 && n > drop0 + 1) req0 = 1'b1;
      if (!req1 && n > drop1 + 1) req1 = 1'b1;
      if (done0 || done1) begin
        vectors++;
        if (done1 !== 1'(k % 2)) begin errs++; $display("FAIL sim_order: done %0d on port %0d want %0d", k, done1, k % 2); end
        if (k > 0) begin
          vectors++;
          if (n - last_n != 2) begin errs++; $display("FAIL sim_spacing: got %0d want 2", n - last_n); end
        end
        if (done0) begin req0 = 1'b0; drop0 = n; end
        else begin req1 = 1'b0; drop1 = n; end
        last_n = n;
        k++;
      end
    end
    vectors++;
    if (k != 4) begin errs++; $display("FAIL sim_count: got %0d want 4", k); end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; a0 = 16'h00AA; b0 = 16'h0055; op0 = 16'h3000;
    tick();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt0, gnt1, done0, done1, err0, err1, res_c, psr0, psr1} !== '0) begin
      errs++; $display("FAIL rstmid_outputs: got %h want 0", {gnt0, gnt1, done0, done1, err0, err1, res_c, psr0, psr1});
    end
    req1 = 1'b1; a1 = 16'h0009; b1 = 16'h0001; op1 = 16'h1000;
    tick();
    vectors++;
    if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
      errs++; $display("FAIL rstmid_held: got %b want 0000", {gnt0, gnt1, done0, done1});
    end
    #2 rst_n = 1'b1;
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin errs++; $display("FAIL rstmid_tie: got %b want 10", {gnt0, gnt1}); end
    tick();
    req0 = 1'b0;
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b01) begin errs++; $display("FAIL rstmid_req1: got %b want 01", {gnt0, gnt1}); end
    req1 = 1'b0;
    tick();
    vectors++;
    if ({done1, res_c} !== {1'b1, 16'h0008}) begin errs++; $display("FAIL rstmid_res: got %h want 10008", {done1, res_c}); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0006; op0 = 16'h0000;
    tick();
    tick();
    vectors++;
    if ({done0, res_c} !== {1'b1, 16'h000B}) begin errs++; $display("FAIL b2b_first: got %h want 1000b", {done0, res_c}); end
    a0 = 16'h0100; b0 = 16'h0020; op0 = 16'h4000;
    tick();
    vectors++;
    if ({gnt0, done0} !== 2'b10) begin errs++; $display("FAIL b2b_regrant: got %b want 10", {gnt0, done0}); end
    a0 = 16'h7777;
    tick();
    vectors++;
    if ({done0, res_c} !== {1'b1, 16'h0120}) begin errs++; $display("FAIL b2b_second: got %h want 10120", {done0, res_c}); end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({gnt0, done0} !== 2'b00) begin errs++; $display("FAIL b2b_idle: got %b want 00", {gnt0, done0}); end
  endtask

  // reference: grants are scheduled by edge number; an edge can grant only two edges after the previous grant
  task automatic test_random();
    int          free_at = 0, g_edge = -10;
    logic        g_own = 1'b0, m_last = 1'b1, gr0 = 1'b0, gr1 = 1'b0;
    logic        e_g0, e_g1, e_d0, e_d1;
    logic [21:0] g_exp = '0;
    logic [47:0] g_ops = '0;
    logic [15:0] m_res = '0;
    logic [5:0]  m_psr0 = '0, m_psr1 = '0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n >= free_at && (req0 || req1)) begin
        g_own = (req0 && req1) ? ~m_last : req1;
        m_last = g_own;
        g_edge = n;
        free_at = n + 2;
        g_ops = g_own ? {a1, b1, op1} : {a0, b0, op0};
        g_exp = alu_fn(g_ops[47:32], g_ops[31:16], g_ops[15:0]);
        if (g_own) gr1 = 1'b1; else gr0 = 1'b1;
      end
      tick();
      e_g0 = (g_edge == n) && !g_own;
      e_g1 = (g_edge == n) && g_own;
      e_d0 = (g_edge == n - 1) && !g_own;
      e_d1 = (g_edge == n - 1) && g_own;
      if (e_d0 || e_d1) begin
        m_res = g_exp[15:0];
        if (e_d0) m_psr0 = g_exp[21:16]; else m_psr1 = g_exp[21:16];
      end
      vectors++;
      if ({gnt0, gnt1, done0, done1} !== {e_g0, e_g1, e_d0, e_d1}) begin
        errs++; $display("FAIL rnd_handshake n=%0d: got %b want %b", n, {gnt0, gnt1, done0, done1}, {e_g0, e_g1, e_d0, e_d1});
      end
      vectors++;
      if ({err0, err1} !== {e_d0 & g_exp[21], e_d1 & g_exp[21]}) begin
        errs++; $display("FAIL rnd_err n=%0d: got %b want %b", n, {err0, err1}, {e_d0 & g_exp[21], e_d1 & g_exp[21]});
      end
      vectors++;
      if ({res_c, psr0, psr1} !== {m_res, m_psr0, m_psr1}) begin
        errs++; $display("FAIL rnd_res_psr n=%0d: got %h want %h", n, {res_c, psr0, psr1}, {m_res, m_psr0, m_psr1});
      end
      vectors++;
      if ({alu_a, alu_b, alu_op} !== g_ops) begin
        errs++; $display("FAIL rnd_alu_in n=%0d: got %h want %h", n, {alu_a, alu_b, alu_op}, g_ops);
      end
      if (req0 && e_d0) begin
        gr0 = 1'b0;
        if ($urandom_range(1) == 1) begin a0 = 16'($urandom); b0 = 16'($urandom); op0 = rop(); end
        else req0 = 1'b0;
      end else if (req0 && gr0) begin
        a0 = 16'($urandom); b0 = 16'($urandom); op0 = rop();
      end else if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom); op0 = rop();
      end
      if (req1 && e_d1) begin
        gr1 = 1'b0;
        if ($urandom_range(1) == 1) begin a1 = 16'($urandom); b1 = 16'($urandom); op1 = rop(); end
        else req1 = 1'b0;
      end else if (req1 && gr1) begin
        a1 = 16'($urandom); b1 = 16'($urandom); op1 = rop();
      end else if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1'b1; a1 = 16'($urandom); b1 = 16'($urandom); op1 = rop();
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_operand_change();
    test_invalid();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
